// File: rtl/core_ifu_pkg.sv
// Shared constants for the instruction-fetch unit: RV opcodes that end a
// fetch run, fetch FSM encoding and a constant-foldable clog2.
package core_ifu_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [0:0] S_RUN     = 1'b0;
    localparam logic [0:0] S_BC_PEND = 1'b1;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/core_ifu_pre_dec.sv
// Minimal predecode: flags control-flow instructions from the opcode field.
module core_ifu_pre_dec
    import core_ifu_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic       is_branch_o
);

    // jal, jalr and conditional branches all redirect fetch.
    always_comb begin
        is_branch_o = (opcode_i == OPC_JAL) || (opcode_i == OPC_JALR) ||
                      (opcode_i == OPC_BRANCH);
    end

endmodule

// File: rtl/core_ifu_fetch_q.sv
// Instruction-fetch queue: issues in-order bus reads for accepted PCs, pairs
// returned words with their PCs and hands them to the IDU. Responses for
// entries killed by a redirect are counted in drop_cnt and discarded.
module core_ifu_fetch_q
    import core_ifu_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 4,
    parameter bit          BC_STALL = 1'b1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            ifu_rx_valid,
    output logic            ifu_rx_ready,
    input  logic [XLEN-1:0] ifu_rx_pc,
    output logic            ifu_tx_valid,
    input  logic            ifu_tx_ready,
    output logic [XLEN-1:0] ifu_tx_pc,
    output logic [XLEN-1:0] ifu_tx_inst,
    output logic            bus_req_valid,
    input  logic            bus_req_ready,
    output logic [XLEN-1:0] bus_req_addr,
    input  logic            bus_rsp_valid,
    input  logic [XLEN-1:0] bus_rsp_data,
    input  logic            ifu_rx_bc_done,
    input  logic            ifu_rx_bc_en
);

    localparam int unsigned PW = clog2(DEPTH);
    localparam int unsigned CW = clog2(DEPTH + 1);

    logic [XLEN-1:0]  pc_q   [DEPTH];
    logic [XLEN-1:0]  inst_q [DEPTH];
    logic [DEPTH-1:0] filled_q, filled_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    fill_ptr_q, fill_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    drop_cnt_q, drop_cnt_d;
    logic [0:0]       state_q, state_d;

    logic          flush, room, accept_ok;
    logic          rx_fire, tx_fire, rsp_fill, rsp_drop;
    logic          head_is_branch;
    logic [CW:0]   occupancy;
    logic [CW-1:0] filled_cnt, unfilled, drop_sum;

    assign flush = ifu_rx_bc_done && ifu_rx_bc_en;

    // Queued entries plus reads still owed for flushed entries bound new issues.
    assign occupancy = {1'b0, count_q} + {1'b0, drop_cnt_q};
    assign room      = occupancy < (CW + 1)'(DEPTH);
    assign accept_ok = rstn && room && (state_q == S_RUN) && !flush;

    // bus_req_ready is kept out of bus_req_valid to avoid a combinational loop.
    assign ifu_rx_ready  = accept_ok && bus_req_ready;
    assign bus_req_valid = accept_ok && ifu_rx_valid;
    assign bus_req_addr  = ifu_rx_pc;
    assign rx_fire       = ifu_rx_valid && ifu_rx_ready;

    assign ifu_tx_pc    = pc_q[rd_ptr_q];
    assign ifu_tx_inst  = inst_q[rd_ptr_q];
    assign ifu_tx_valid = rstn && filled_q[rd_ptr_q] && (count_q != '0) &&
                          (state_q == S_RUN) && !flush;
    assign tx_fire      = ifu_tx_valid && ifu_tx_ready;

    // A response in the flush cycle belongs to a killed entry and is dropped.
    assign rsp_drop = bus_rsp_valid && (drop_cnt_q != '0);
    assign rsp_fill = bus_rsp_valid && (drop_cnt_q == '0) && !flush;

    core_ifu_pre_dec u_pre_dec (
        .opcode_i    (ifu_tx_inst[6:0]),
        .is_branch_o (head_is_branch)
    );

    // Count live entries whose data has already returned (cleared on pop).
    always_comb begin
        filled_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            filled_cnt = filled_cnt + CW'(filled_q[i]);
        end
    end

    // Reads owed after a flush: old debt plus every unfilled entry, less the
    // response that lands this cycle (it pays off one of the two either way).
    assign unfilled = count_q - filled_cnt;
    assign drop_sum = unfilled + drop_cnt_q - CW'(bus_rsp_valid);

    // Pointer, occupancy, fill-bit and drop-debt bookkeeping.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        fill_ptr_d = fill_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;
        filled_d   = filled_q;
        if (flush) begin
            wr_ptr_d   = '0;
            fill_ptr_d = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            filled_d   = '0;
            drop_cnt_d = drop_sum;
        end else begin
            if (rsp_drop) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            if (rsp_fill) begin
                filled_d[fill_ptr_q] = 1'b1;
                fill_ptr_d           = fill_ptr_q + PW'(1);
            end
            if (tx_fire) begin
                filled_d[rd_ptr_q] = 1'b0;
                rd_ptr_d           = rd_ptr_q + PW'(1);
            end
            if (rx_fire) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(rx_fire) - CW'(tx_fire);
        end
    end

    // Stall PC intake after a control-flow instruction leaves, until resolved.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_RUN;
        end else if (state_q == S_BC_PEND) begin
            if (ifu_rx_bc_done) begin
                state_d = S_RUN;
            end
        end else if (BC_STALL && tx_fire && head_is_branch) begin
            state_d = S_BC_PEND;
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            fill_ptr_q <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
            filled_q   <= '0;
            state_q    <= S_RUN;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            fill_ptr_q <= fill_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
            filled_q   <= filled_d;
            state_q    <= state_d;
        end
    end

    // Entry payload; unreset because filled_q/count_q qualify every read.
    always_ff @(posedge clk) begin
        if (rx_fire) begin
            pc_q[wr_ptr_q] <= ifu_rx_pc;
        end
        if (rsp_fill) begin
            inst_q[fill_ptr_q] <= bus_rsp_data;
        end
    end

endmodule

// File: tb/tb_core_ifu_fetch_q.sv
// Bench for core_ifu_fetch_q: an in-order bus responder plus a queue-level
// reference model checked every cycle, with directed scenarios pinned by
// literal expectations and a randomized soak.
module tb_core_ifu_fetch_q;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned DEPTH    = 4;
    localparam bit          BC_STALL = 1'b1;

    logic            clk = 1'b0;
    logic            rstn;
    logic            ifu_rx_valid, ifu_rx_ready;
    logic [XLEN-1:0] ifu_rx_pc;
    logic            ifu_tx_valid, ifu_tx_ready;
    logic [XLEN-1:0] ifu_tx_pc, ifu_tx_inst;
    logic            bus_req_valid, bus_req_ready;
    logic [XLEN-1:0] bus_req_addr;
    logic            bus_rsp_valid;
    logic [XLEN-1:0] bus_rsp_data;
    logic            bc_done, bc_en;

    core_ifu_fetch_q #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .BC_STALL (BC_STALL)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .ifu_rx_valid   (ifu_rx_valid),
        .ifu_rx_ready   (ifu_rx_ready),
        .ifu_rx_pc      (ifu_rx_pc),
        .ifu_tx_valid   (ifu_tx_valid),
        .ifu_tx_ready   (ifu_tx_ready),
        .ifu_tx_pc      (ifu_tx_pc),
        .ifu_tx_inst    (ifu_tx_inst),
        .bus_req_valid  (bus_req_valid),
        .bus_req_ready  (bus_req_ready),
        .bus_req_addr   (bus_req_addr),
        .bus_rsp_valid  (bus_rsp_valid),
        .bus_rsp_data   (bus_rsp_data),
        .ifu_rx_bc_done (bc_done),
        .ifu_rx_bc_en   (bc_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          filled;
    } ent_t;

    ent_t        mq[$];    // model queue, head at index 0
    logic [31:0] pend[$];  // addresses the bus still owes, in order
    int          m_drop = 0;
    bit          m_stall = 1'b0;
    bit          last_fire = 1'b0;
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] nxt_pc;

    // Memory image: low directed region is all addi except a jal at 0x10.
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        logic [6:0]  op;
        logic [2:0]  s;
        logic [24:0] hi;
        if (a == 32'h10) return 32'h0000_006F;
        if (a < 32'h1000) return 32'h0000_0013;
        s  = a[6:4];
        hi = a[31:7] ^ 25'h0A5A5A5;
        case (s)
            3'd5:    op = 7'h6F;
            3'd6:    op = 7'h63;
            3'd7:    op = a[7] ? 7'h67 : 7'h13;
            default: op = 7'h13;
        endcase
        return {hi, op};
    endfunction

    function automatic bit is_br(input logic [31:0] inst);
        logic [6:0] op;
        op = inst[6:0];
        return (op == 7'h6F) || (op == 7'h67) || (op == 7'h63);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive_rsp(input int mode);
        if (rstn && pend.size() > 0 &&
            (mode == 0 || (mode == 1 && $urandom_range(0, 99) < 65))) begin
            bus_rsp_valid = 1'b1;
            bus_rsp_data  = inst_of(pend[0]);
        end else begin
            bus_rsp_valid = 1'b0;
            bus_rsp_data  = $urandom;
        end
    endtask

    task automatic drive(input bit rv, input logic [31:0] pc, input bit txr,
                         input bit bcd, input bit bce, input int mode);
        ifu_rx_valid  = rv;
        ifu_rx_pc     = pc;
        ifu_tx_ready  = txr;
        bus_req_ready = 1'b1;
        bc_done       = bcd;
        bc_en         = bce;
        drive_rsp(mode);
    endtask

    // Compare the DUT against the model for this cycle, then advance the model.
    task automatic step();
        int unf;
        int occ;
        bit fl, e_acc, e_ready, e_req, e_txv, e_fire;
        #1;
        if (!rstn) begin
            chk("rst_tx_valid", ifu_tx_valid, 0);
            chk("rst_req_valid", bus_req_valid, 0);
            mq.delete();
            pend.delete();
            m_drop    = 0;
            m_stall   = 1'b0;
            last_fire = 1'b0;
        end else begin
            occ     = mq.size() + m_drop;
            fl      = bc_done && bc_en;
            e_acc   = (occ < DEPTH) && !m_stall && !fl;
            e_ready = e_acc && bus_req_ready;
            e_req   = e_acc && ifu_rx_valid;
            e_txv   = 1'b0;
            if (mq.size() > 0) e_txv = mq[0].filled && !m_stall && !fl;
            chk("rx_ready", ifu_rx_ready, e_ready);
            chk("req_valid", bus_req_valid, e_req);
            chk("tx_valid", ifu_tx_valid, e_txv);
            if (e_req) chk("req_addr", bus_req_addr, ifu_rx_pc);
            if (e_txv) begin
                chk("tx_pc", ifu_tx_pc, mq[0].pc);
                chk("tx_inst", ifu_tx_inst, mq[0].inst);
            end
            e_fire    = ifu_rx_valid && e_ready;
            last_fire = e_fire;
            if (bus_rsp_valid) void'(pend.pop_front());
            if (fl) begin
                unf = 0;
                foreach (mq[i]) if (!mq[i].filled) unf++;
                m_drop  = unf + m_drop - (bus_rsp_valid ? 1 : 0);
                mq.delete();
                m_stall = 1'b0;
            end else begin
                if (bus_rsp_valid) begin
                    if (m_drop > 0) begin
                        m_drop--;
                    end else begin
                        for (int i = 0; i < mq.size(); i++) begin
                            if (!mq[i].filled) begin
                                mq[i].inst   = bus_rsp_data;
                                mq[i].filled = 1'b1;
                                break;
                            end
                        end
                    end
                end
                if (m_stall) begin
                    if (bc_done) m_stall = 1'b0;
                end else if (e_txv && ifu_tx_ready) begin
                    if (BC_STALL && is_br(mq[0].inst)) m_stall = 1'b1;
                    void'(mq.pop_front());
                end
                if (e_fire) begin
                    mq.push_back('{pc: ifu_rx_pc, inst: 32'h0, filled: 1'b0});
                    pend.push_back(ifu_rx_pc);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 0);
            step();
        end
    endtask

    initial begin
        rstn = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2);
        @(negedge clk);
        step();
        step();

        // Release: ready follows bus_req_ready, nothing to send.
        rstn = 1'b1;
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 0);
        #1;
        chk("lit_post_rst_ready", ifu_rx_ready, 1);
        chk("lit_post_rst_txv", ifu_tx_valid, 0);
        step();

        // Straight line: 0x0..0xC, first pair at cycle 2, one per cycle.
        for (int c = 0; c < 7; c++) begin
            drive(c < 4, 32'(c * 4), 1'b1, 1'b0, 1'b0, 0);
            #1;
            if (c < 2 || c == 6) chk("lit_line_txv_idle", ifu_tx_valid, 0);
            if (c >= 2 && c <= 5) begin
                chk("lit_line_txv", ifu_tx_valid, 1);
                chk("lit_line_pc", ifu_tx_pc, 32'((c - 2) * 4));
                chk("lit_line_inst", ifu_tx_inst, 32'h13);
            end
            step();
        end
        drain(3);

        // Backpressure: four accepted, full, then one slot after the first pop.
        nxt_pc = 32'h20;
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, nxt_pc, c >= 6, 1'b0, 1'b0, 0);
            #1;
            chk("lit_full_ready", ifu_rx_ready, (c < 4 || c == 7) ? 1 : 0);
            if (c == 6) chk("lit_full_head", ifu_tx_pc, 32'h20);
            if (c == 7) chk("lit_full_5th_pc", ifu_rx_pc, 32'h30);
            step();
            if (last_fire) nxt_pc = nxt_pc + 32'h4;
        end
        drain(8);

        // Branch stall: jal at 0x10 blocks until bc_done, then 0x14 drains.
        for (int c = 0; c < 8; c++) begin
            drive(c < 2, (c == 0) ? 32'h10 : 32'h14, 1'b1, c == 6, 1'b0, 0);
            #1;
            if (c == 2) begin
                chk("lit_br_pc", ifu_tx_pc, 32'h10);
                chk("lit_br_inst", ifu_tx_inst, 32'h6F);
            end
            if (c >= 3 && c <= 6) begin
                chk("lit_br_stall_txv", ifu_tx_valid, 0);
                chk("lit_br_stall_ready", ifu_rx_ready, 0);
            end
            if (c == 7) begin
                chk("lit_br_release_txv", ifu_tx_valid, 1);
                chk("lit_br_release_pc", ifu_tx_pc, 32'h14);
            end
            step();
        end
        drain(4);

        // Redirect flush: three outstanding, one filled; two late replies dropped.
        for (int c = 0; c < 8; c++) begin
            case (c)
                0: drive(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 2);
                1: drive(1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 0);
                2: drive(1'b1, 32'h48, 1'b0, 1'b0, 1'b0, 2);
                3: drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 2);
                4: drive(1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 0);
                default: drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 0);
            endcase
            #1;
            if (c == 2) chk("lit_fl_pre_pc", ifu_tx_pc, 32'h40);
            if (c >= 3 && c <= 6) chk("lit_fl_txv", ifu_tx_valid, 0);
            if (c == 7) begin
                chk("lit_fl_new_txv", ifu_tx_valid, 1);
                chk("lit_fl_new_pc", ifu_tx_pc, 32'h80);
            end
            step();
        end
        drain(4);

        // Flush with a same-cycle response: one reply still owed afterwards.
        for (int c = 0; c < 6; c++) begin
            case (c)
                0: drive(1'b1, 32'h50, 1'b0, 1'b0, 1'b0, 2);
                1: drive(1'b1, 32'h54, 1'b0, 1'b0, 1'b0, 2);
                2: drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 0);
                3: drive(1'b1, 32'h90, 1'b1, 1'b0, 1'b0, 0);
                default: drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 0);
            endcase
            #1;
            if (c >= 2 && c <= 4) chk("lit_flr_txv", ifu_tx_valid, 0);
            if (c == 5) chk("lit_flr_pc", ifu_tx_pc, 32'h90);
            step();
        end
        drain(4);

        // Reset mid-run with three entries queued.
        for (int c = 0; c < 6; c++) begin
            rstn = (c != 3);
            drive(c < 3, 32'h60 + 32'(c * 4), 1'b0, 1'b0, 1'b0, 0);
            #1;
            if (c == 2) chk("lit_rst_pre_pc", ifu_tx_pc, 32'h60);
            if (c == 4) begin
                chk("lit_rst_txv", ifu_tx_valid, 0);
                chk("lit_rst_ready", ifu_rx_ready, 1);
            end
            step();
        end

        // Randomized soak against the model.
        for (int k = 0; k < 3000; k++) begin
            rstn          = ($urandom_range(0, 499) != 0);
            ifu_rx_valid  = ($urandom_range(0, 99) < 70);
            ifu_rx_pc     = 32'h1000 + 32'($urandom_range(0, 4095) << 2);
            ifu_tx_ready  = ($urandom_range(0, 99) < 70);
            bus_req_ready = ($urandom_range(0, 99) < 80);
            bc_done       = m_stall ? ($urandom_range(0, 99) < 25) : ($urandom_range(0, 99) < 3);
            bc_en         = 1'($urandom_range(0, 1));
            drive_rsp(1);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
